phys_reg_ready_table: RTL
=========================

Name: phys_reg_ready_table

Overview:
- Ready-bit scoreboard for the physical register file.
- Consumes the per-cycle wakeup tag broadcasts from the result shift register (FU0/FU1/FU2 tags) and from the load/store unit (load tag).
- Clears ready bits for destinations allocated at rename/dispatch.
- Returns registered ready status for every source operand of the dispatch bundle, so each instruction enters the issue queue with correct initial ready bits.

Parameters:
- SIZE_PHYSICAL, 96, number of physical registers.
- SIZE_PHYSICAL_LOG, 7, tag width; must satisfy 2^SIZE_PHYSICAL_LOG >= SIZE_PHYSICAL.
- DISPATCH_WIDTH, 4, instructions per dispatch bundle.
- WAKE_PORTS, 4, wakeup ports: 0..2 = result shift register tags 0..2, 3 = load tag.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- stall_i  in  1  dispatch stalled this cycle.
- wakeValid_i  in  WAKE_PORTS  per-port broadcast valid.
- wakeTag_i  in  WAKE_PORTS*SIZE_PHYSICAL_LOG  packed broadcast tags; port p occupies bits [p*SIZE_PHYSICAL_LOG +: SIZE_PHYSICAL_LOG].
- allocValid_i  in  DISPATCH_WIDTH  slot i allocates a destination.
- allocTag_i  in  DISPATCH_WIDTH*SIZE_PHYSICAL_LOG  packed destination tags.
- srcValid_i  in  2*DISPATCH_WIDTH  source k of slot i is valid at index 2i+k.
- srcTag_i  in  2*DISPATCH_WIDTH*SIZE_PHYSICAL_LOG  packed source tags, same indexing as srcValid_i.
- srcReady_o  out  2*DISPATCH_WIDTH  registered ready bit per source.

Behaviour:
- State: READY[SIZE_PHYSICAL-1:0], one bit per physical register.
- Reset (synchronous): READY set to all ones; srcReady_o cleared to 0.
  - Reset asserted mid-operation discards all same-cycle allocations and wakeups.
- Effective inputs:
  - Wakeup on port p counts only when wakeValid_i[p] = 1.
  - Allocation on slot i counts only when allocValid_i[i] = 1 and stall_i = 0.
- Table update at each posedge:
  - READY[t] <= 0 if any effective allocation targets t.
  - Otherwise READY[t] <= 1 if any effective wakeup targets t.
  - Otherwise READY[t] holds.
  - Allocation beats wakeup for the same tag in the same cycle.
- Duplicate wakeups of one tag on several ports in a cycle are legal and idempotent.
- Tags >= SIZE_PHYSICAL are ignored on every port, with no wraparound or aliasing.
- Read path, one-cycle latency. Sources are sampled at cycle t; srcReady_o is valid in cycle t+1.
  - For source k of slot j: ready = srcValid AND (READY[tag] at t OR any effective wakeup of tag at t) AND NOT (any effective allocation of tag by an older slot i < j at t).
  - A same-cycle wakeup bypasses the table, so a tag broadcast in cycle t reads ready.
  - Intra-bundle RAW dependence forces not-ready even if the table bit or a wakeup is set.
  - Allocation by the same slot or a younger slot (i >= j) does not affect slot j's read.
  - An invalid source reads 0.
- Stall: when stall_i = 1, srcReady_o holds its previous value and allocations are ignored. Wakeups still update READY.
- There is no internal branch-mask handling.
  - The upstream broadcaster already suppresses wakeups of squashed instructions.
  - Squashed destinations need no restore: a register is re-cleared when it is reallocated.
- Implementation: purely synchronous, no latches. The read mux and bypass are computed from pre-update table contents.

Test Plan:
- Reset, then read srcTag = 5, 17, 95 with valid set -> srcReady_o = 1 for all three in the next cycle. An invalid source reads 0.
- Allocate tag 20 in slot 0 at cycle 1; read tag 20 from slot 0 at cycle 2 -> srcReady_o = 0. Wake tag 20 on port 1 at cycle 3; read at cycle 4 -> 1.
- Same cycle: slot 0 allocates tag 33 and slot 2 source 0 reads tag 33 -> that source reads 0. Slot 0 source 1 reading tag 33 reads the prior table value, 1.
- Tag 40 not ready; wake 40 on port 3 in the same cycle slot 1 reads 40 -> srcReady_o = 1 next cycle, and READY[40] = 1 afterward.
- Allocate tag 50 and wake tag 50 in the same cycle -> READY[50] = 0. Also wake tag 50 on ports 0 and 2 together after clearing -> READY[50] = 1 with no error.
- stall_i = 1 with allocValid set for tag 60 and a wakeup of tag 61 (61 previously cleared) -> READY[60] stays 1, READY[61] becomes 1, srcReady_o unchanged. Assert reset mid-stream -> all ready, outputs 0.

Source files
------------

// File: rtl/phys_reg_ready_table.sv
// phys_reg_ready_table
// Ready-bit scoreboard for the physical register file. One bit per physical
// register records whether its value has been produced. Wakeup broadcasts set
// bits, destination allocations at dispatch clear them, and every source of
// the dispatch bundle gets a registered ready bit one cycle after it is read.
//
// Ports:
//   clk           clock
//   reset         synchronous, active-high reset (table all ready, outputs 0)
//   stall_i       dispatch stalled: allocations ignored, srcReady_o holds
//   wakeValid_i   per-port wakeup valid (ports 0..2 result shift reg, 3 load)
//   wakeTag_i     packed wakeup tags, port p at [p*SIZE_PHYSICAL_LOG +: SIZE_PHYSICAL_LOG]
//   allocValid_i  per-slot destination allocation valid
//   allocTag_i    packed destination tags, slot i at [i*SIZE_PHYSICAL_LOG +: ...]
//   srcValid_i    per-source valid, source k of slot i at index 2i+k
//   srcTag_i      packed source tags, same indexing as srcValid_i
//   srcReady_o    registered ready bit per source
module phys_reg_ready_table #(
    parameter int unsigned SIZE_PHYSICAL     = 96,
    parameter int unsigned SIZE_PHYSICAL_LOG = 7,
    parameter int unsigned DISPATCH_WIDTH    = 4,
    parameter int unsigned WAKE_PORTS        = 4
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          stall_i,
    input  logic [WAKE_PORTS-1:0]                         wakeValid_i,
    input  logic [WAKE_PORTS*SIZE_PHYSICAL_LOG-1:0]       wakeTag_i,
    input  logic [DISPATCH_WIDTH-1:0]                     allocValid_i,
    input  logic [DISPATCH_WIDTH*SIZE_PHYSICAL_LOG-1:0]   allocTag_i,
    input  logic [2*DISPATCH_WIDTH-1:0]                   srcValid_i,
    input  logic [2*DISPATCH_WIDTH*SIZE_PHYSICAL_LOG-1:0] srcTag_i,
    output logic [2*DISPATCH_WIDTH-1:0]                   srcReady_o
);

    localparam int unsigned TAG_W   = SIZE_PHYSICAL_LOG;
    localparam int unsigned NUM_SRC = 2 * DISPATCH_WIDTH;

    logic [SIZE_PHYSICAL-1:0]  readyTable;
    logic [SIZE_PHYSICAL-1:0]  readyNext;
    logic [SIZE_PHYSICAL-1:0]  wakeHit;
    logic [SIZE_PHYSICAL-1:0]  allocHit;
    logic [DISPATCH_WIDTH-1:0] allocEff;
    logic [NUM_SRC-1:0]        srcReadyNext;

    // Allocations only take effect on cycles where dispatch actually proceeds.
    assign allocEff = allocValid_i & {DISPATCH_WIDTH{~stall_i}};

    // Decode wakeups and allocations into one-hot-per-register vectors;
    // tags beyond the register file are dropped rather than aliased.
    always_comb begin
        logic [TAG_W-1:0] tag;
        wakeHit  = '0;
        allocHit = '0;
        tag      = '0;
        for (int unsigned p = 0; p < WAKE_PORTS; p++) begin
            tag = wakeTag_i[p*TAG_W +: TAG_W];
            if (wakeValid_i[p] && (32'(tag) < SIZE_PHYSICAL)) begin
                wakeHit[tag] = 1'b1;
            end
        end
        for (int unsigned i = 0; i < DISPATCH_WIDTH; i++) begin
            tag = allocTag_i[i*TAG_W +: TAG_W];
            if (allocEff[i] && (32'(tag) < SIZE_PHYSICAL)) begin
                allocHit[tag] = 1'b1;
            end
        end
    end

    // Allocation wins over a same-cycle wakeup of the same register.
    assign readyNext = (readyTable | wakeHit) & ~allocHit;

    // Source lookup on pre-update contents, with wakeup bypass and
    // squashing by destinations allocated in older slots of the bundle.
    always_comb begin
        logic [TAG_W-1:0] tag;
        logic             rdy;
        srcReadyNext = '0;
        tag          = '0;
        rdy          = 1'b0;
        for (int unsigned s = 0; s < NUM_SRC; s++) begin
            tag = srcTag_i[s*TAG_W +: TAG_W];
            rdy = 1'b0;
            if (srcValid_i[s] && (32'(tag) < SIZE_PHYSICAL)) begin
                rdy = readyTable[tag] | wakeHit[tag];
                for (int unsigned i = 0; i < DISPATCH_WIDTH; i++) begin
                    if ((i < (s >> 1)) && allocEff[i] &&
                        (allocTag_i[i*TAG_W +: TAG_W] == tag)) begin
                        rdy = 1'b0;
                    end
                end
            end
            srcReadyNext[s] = rdy;
        end
    end

    // Table and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            readyTable <= '1;
            srcReady_o <= '0;
        end else begin
            readyTable <= readyNext;
            if (!stall_i) begin
                srcReady_o <= srcReadyNext;
            end
        end
    end

endmodule
